// File: rtl/sr_drv.sv
// sr_drv: pulses set/reset lines of WIDTH external SR flops toward a target
// pattern, waits for them to settle, then reports completion.
// Optional macro SR_DRV_VERIFY_EN: check q_fb against the target, report
// mismatches on err/err_mask and track cur from q_fb instead of the target.
module sr_drv #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned PULSE_CYC  = 1,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_target,
  output logic             in_ready,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] err_mask,
  output logic [WIDTH-1:0] cur
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] s_nxt_q, s_nxt_d;
  logic [WIDTH-1:0] r_nxt_q, r_nxt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] err_mask_q, err_mask_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic             in_ready_q, in_ready_d;
  logic             xfer_c;
  logic [WIDTH-1:0] chk_mask_c;
  logic [WIDTH-1:0] cur_upd_c;

  // Handshake: accepted only while sitting in IDLE
  assign xfer_c = in_valid & (state_q == IDLE);

`ifdef SR_DRV_VERIFY_EN
  // Mismatch is read back from the driven flops; cur follows what they hold
  assign chk_mask_c = q_fb ^ tgt_q;
  assign cur_upd_c  = q_fb;
`else
  // Open-loop: assume the flops took the target, feedback is ignored
  logic unused_q_fb;
  assign unused_q_fb = ^q_fb;
  assign chk_mask_c  = '0;
  assign cur_upd_c   = tgt_q;
`endif

  // Capture target and the disjoint set/reset patterns on a transfer
  always_comb begin
    tgt_d   = tgt_q;
    s_nxt_d = s_nxt_q;
    r_nxt_d = r_nxt_q;
    if (xfer_c) begin
      tgt_d   = in_target;
      s_nxt_d = in_target & ~cur_q;
      r_nxt_d = ~in_target & cur_q;
    end
  end

  // Next-state and phase counter; counter reloads on every state entry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (xfer_c) begin
          if (in_target != cur_q) begin
            state_d = DRIVE;
            cnt_d   = PULSE_LD;
          end else begin
            state_d = CHECK;
            cnt_d   = '0;
          end
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = CHECK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CHECK: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered outputs decoded from the upcoming state so they align with it
  always_comb begin
    s_d        = '0;
    r_d        = '0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_mask_d = err_mask_q;
    cur_d      = cur_q;
    in_ready_d = (state_d == IDLE);
    if (state_d == DRIVE) begin
      s_d = s_nxt_d;
      r_d = r_nxt_d;
    end
    if (state_q == CHECK) begin
      done_d     = 1'b1;
      err_d      = |chk_mask_c;
      err_mask_d = chk_mask_c;
      cur_d      = cur_upd_c;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Datapath and output registers; reset aborts any operation silently
  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_q      <= '0;
      s_nxt_q    <= '0;
      r_nxt_q    <= '0;
      s_q        <= '0;
      r_q        <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_mask_q <= '0;
      cur_q      <= '0;
      in_ready_q <= 1'b1;
    end else begin
      tgt_q      <= tgt_d;
      s_nxt_q    <= s_nxt_d;
      r_nxt_q    <= r_nxt_d;
      s_q        <= s_d;
      r_q        <= r_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_mask_q <= err_mask_d;
      cur_q      <= cur_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign s        = s_q;
  assign r        = r_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_mask = err_mask_q;
  assign cur      = cur_q;
  assign in_ready = in_ready_q;

endmodule

// File: tb/tb_sr_drv.sv
// Testbench for sr_drv (WIDTH=4, PULSE_CYC=2, SETTLE_CYC=1). The driven SR
// flops are modelled behaviourally; expectations come from the target/cur rules.
module tb_sr_drv;

  localparam int unsigned W = 4;
  localparam int unsigned P = 2;
  localparam int unsigned S = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, done, err;
  logic [W-1:0] in_target, q_fb, s, r, err_mask, cur;
  logic [W-1:0] q_model, stuck_val;
  logic         stuck_en;
  int           total, bad;

  sr_drv #(.WIDTH(W), .PULSE_CYC(P), .SETTLE_CYC(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_target(in_target),
    .in_ready(in_ready), .q_fb(q_fb), .s(s), .r(r), .done(done), .err(err),
    .err_mask(err_mask), .cur(cur)
  );

  // Behavioural SR flop bank; optional stuck override on the feedback
  always @(posedge clk) begin
    if (rst) q_model <= '0;
    else     q_model <= (q_model & ~r) | s;
  end
  assign q_fb = stuck_en ? stuck_val : q_model;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Start at a negedge with the DUT idle; returns at the negedge of the done cycle
  task automatic run_op(input logic [W-1:0] t, input bit hold,
                        output int lat, output bit got,
                        output logic [W-1:0] s_or, output logic [W-1:0] r_or,
                        output int drv, output bit ovl, output int rdy_busy,
                        output logic rdy_done, output logic err_o,
                        output logic [W-1:0] mask_o, output logic [W-1:0] cur_o);
    s_or = '0; r_or = '0; drv = 0; ovl = 1'b0; rdy_busy = 0; got = 1'b0;
    rdy_done = 1'b0; err_o = 1'b0; mask_o = '0; cur_o = '0;
    in_target = t;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = hold;
    lat = 1;
    while (!got && lat < 40) begin
      @(negedge clk);
      if ((s | r) != '0) drv++;
      s_or = s_or | s;
      r_or = r_or | r;
      if ((s & r) != '0) ovl = 1'b1;
      if (done === 1'b1) begin
        got = 1'b1; err_o = err; mask_o = err_mask; cur_o = cur; rdy_done = in_ready;
      end else begin
        if (in_ready === 1'b1) rdy_busy++;
        @(posedge clk); #1;
        lat++;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [3+4*W-1:0] obs, exp;
    do_reset();
    obs = {in_ready, done, err, s, r, err_mask, cur};
    exp = {1'b1, 1'b0, 1'b0, {(4*W){1'b0}}};
    total++;
    if (obs !== exp) begin
      bad++; $display("FAIL reset_state got=%h exp=%h", obs, exp);
    end
  endtask

  // Reset wins over a transfer presented in the same cycle
  task automatic test_rst_priority();
    int act, dn;
    act = 0; dn = 0;
    in_target = 4'hF; in_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if ((s | r) != '0) act++;
      if (done === 1'b1) dn++;
    end
    total++;
    if (act !== 0 || dn !== 0) begin
      bad++; $display("FAIL rst_priority sr_cycles=%0d done_cycles=%0d exp=0/0", act, dn);
    end
    total++;
    if (in_ready !== 1'b1 || cur !== 4'h0) begin
      bad++; $display("FAIL rst_priority_idle rdy=%b cur=%b exp=1/0000", in_ready, cur);
    end
  endtask

  task automatic test_set_pattern();
    int lat, drv, rb; bit got, ovl; logic rd, e; logic [W-1:0] so, ro, m, c;
    run_op(4'b1010, 1'b0, lat, got, so, ro, drv, ovl, rb, rd, e, m, c);
    total++;
    if (!got || lat !== int'(P + S + 2)) begin
      bad++; $display("FAIL set_latency got=%0d lat=%0d exp=%0d", got, lat, P + S + 2);
    end
    total++;
    if (so !== 4'b1010 || ro !== 4'b0000 || drv !== int'(P)) begin
      bad++; $display("FAIL set_drive s=%b r=%b cyc=%0d exp=1010/0000/%0d", so, ro, drv, P);
    end
    total++;
    if (c !== 4'b1010 || e !== 1'b0) begin
      bad++; $display("FAIL set_cur cur=%b err=%b exp=1010/0", c, e);
    end
  endtask

  task automatic test_mixed();
    int lat, drv, rb; bit got, ovl; logic rd, e; logic [W-1:0] so, ro, m, c;
    run_op(4'b0110, 1'b0, lat, got, so, ro, drv, ovl, rb, rd, e, m, c);
    total++;
    if (so !== 4'b0100 || ro !== 4'b1000 || drv !== int'(P)) begin
      bad++; $display("FAIL mixed_drive s=%b r=%b cyc=%0d exp=0100/1000/%0d", so, ro, drv, P);
    end
    total++;
    if (ovl !== 1'b0) begin
      bad++; $display("FAIL mixed_overlap s&r seen=%b exp=0", ovl);
    end
    total++;
    if (!got || c !== 4'b0110 || lat !== int'(P + S + 2)) begin
      bad++; $display("FAIL mixed_cur got=%0d cur=%b lat=%0d exp=0110/%0d", got, c, lat, P + S + 2);
    end
  endtask

  task automatic test_equal();
    int lat, drv, rb; bit got, ovl; logic rd, e; logic [W-1:0] so, ro, m, c;
    run_op(4'b0110, 1'b0, lat, got, so, ro, drv, ovl, rb, rd, e, m, c);
    total++;
    if (!got || lat !== 2) begin
      bad++; $display("FAIL equal_latency got=%0d lat=%0d exp=2", got, lat);
    end
    total++;
    if (drv !== 0 || c !== 4'b0110) begin
      bad++; $display("FAIL equal_noact sr_cycles=%0d cur=%b exp=0/0110", drv, c);
    end
  endtask

  // in_valid held while busy, then a new target taken in the done cycle
  task automatic test_back_to_back();
    int lat, drv, rb; bit got, ovl; logic rd, e; logic [W-1:0] so, ro, m, c;
    run_op(4'b0001, 1'b1, lat, got, so, ro, drv, ovl, rb, rd, e, m, c);
    total++;
    if (!got || rb !== 0 || lat !== int'(P + S + 2)) begin
      bad++; $display("FAIL busy_hold got=%0d rdy_busy=%0d lat=%0d exp=0/%0d", got, rb, lat, P + S + 2);
    end
    total++;
    if (rd !== 1'b1 || c !== 4'b0001) begin
      bad++; $display("FAIL busy_done rdy=%b cur=%b exp=1/0001", rd, c);
    end
    run_op(4'b1000, 1'b0, lat, got, so, ro, drv, ovl, rb, rd, e, m, c);
    total++;
    if (!got || lat !== int'(P + S + 2) || so !== 4'b1000 || ro !== 4'b0001) begin
      bad++; $display("FAIL b2b got=%0d lat=%0d s=%b r=%b exp=%0d/1000/0001", got, lat, so, ro, P + S + 2);
    end
    total++;
    if (c !== 4'b1000) begin
      bad++; $display("FAIL b2b_cur cur=%b exp=1000", c);
    end
  endtask

  task automatic test_rst_mid_drive();
    int dn;
    dn = 0;
    in_target = 4'b0111; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (s !== 4'b0111 || r !== 4'b1000) begin
      bad++; $display("FAIL mid_drive_active s=%b r=%b exp=0111/1000", s, r);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (s !== 4'b0 || r !== 4'b0 || cur !== 4'b0 || in_ready !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL mid_drive_abort s=%b r=%b cur=%b rdy=%b done=%b exp=0/0/0/1/0",
                      s, r, cur, in_ready, done);
    end
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1 || err === 1'b1) dn++;
    end
    total++;
    if (dn !== 0) begin
      bad++; $display("FAIL mid_drive_nodone pulses=%0d exp=0", dn);
    end
  endtask

`ifdef SR_DRV_VERIFY_EN
  task automatic test_verify();
    int lat, drv, rb; bit got, ovl; logic rd, e; logic [W-1:0] so, ro, m, c;
    do_reset();
    stuck_val = 4'b0111; stuck_en = 1'b1;
    run_op(4'b1111, 1'b0, lat, got, so, ro, drv, ovl, rb, rd, e, m, c);
    total++;
    if (!got || e !== 1'b1 || m !== 4'b1000) begin
      bad++; $display("FAIL verify_err got=%0d err=%b mask=%b exp=1/1000", got, e, m);
    end
    total++;
    if (c !== 4'b0111) begin
      bad++; $display("FAIL verify_cur cur=%b exp=0111", c);
    end
    stuck_en = 1'b0;
    do_reset();
  endtask
`endif

  // Random targets against a cur/target model of the operation
  task automatic test_random();
    int lat, drv, rb; bit got, ovl; logic rd, e; logic [W-1:0] so, ro, m, c;
    logic [W-1:0] t, cm, es, er;
    int elat, edrv;
    do_reset();
    cm = '0;
    for (int i = 0; i < 40; i++) begin
      t    = W'($urandom);
      if (i % 7 == 3) t = cm;
      es   = t & ~cm;
      er   = ~t & cm;
      edrv = (t != cm) ? int'(P) : 0;
      elat = (t != cm) ? int'(P + S + 2) : 2;
      run_op(t, 1'($urandom_range(0, 1)), lat, got, so, ro, drv, ovl, rb, rd, e, m, c);
      total++;
      if (!got || lat !== elat || rb !== 0) begin
        bad++; $display("FAIL rand_timing i=%0d got=%0d lat=%0d rdy_busy=%0d exp=%0d/0", i, got, lat, rb, elat);
      end
      total++;
      if (so !== es || ro !== er || drv !== edrv || ovl !== 1'b0) begin
        bad++; $display("FAIL rand_drive i=%0d s=%b r=%b cyc=%0d ovl=%b exp=%b/%b/%0d/0",
                        i, so, ro, drv, ovl, es, er, edrv);
      end
      total++;
      if (c !== t || e !== 1'b0 || m !== 4'b0) begin
        bad++; $display("FAIL rand_result i=%0d cur=%b err=%b mask=%b exp=%b/0/0000", i, c, e, m, t);
      end
      cm = t;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; in_valid = 1'b0; in_target = '0;
    stuck_en = 1'b0; stuck_val = '0;
    test_reset();
    test_rst_priority();
    test_set_pattern();
    test_mixed();
    test_equal();
    test_back_to_back();
    test_rst_mid_drive();
`ifdef SR_DRV_VERIFY_EN
    test_verify();
`endif
    test_random();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sr_drv.md
SR_DRV -- requirements
Module: sr_drv

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the number of SR flip-flops driven.
REQ-002 SHALL have parameter PULSE_CYC, default 1, range 1..15, giving the number of cycles s/r are held asserted.
REQ-003 SHALL have parameter SETTLE_CYC, default 1, range 1..15, giving the number of cycles waited after the pulse before the check.
REQ-004 SHALL have port clk  input  1  as the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  as the reset, synchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  to present a new target pattern.
REQ-007 SHALL have port in_target  input  WIDTH  as the target q value for each flop.
REQ-008 SHALL have port in_ready  output  1  high when a target can be accepted.
REQ-009 SHALL have port q_fb  input  WIDTH  as the q feedback from the driven flops.
REQ-010 SHALL have port s  output  WIDTH  as the registered set drive per flop.
REQ-011 SHALL have port r  output  WIDTH  as the registered reset drive per flop.
REQ-012 SHALL have port done  output  1  as a one-cycle completion pulse.
REQ-013 SHALL have port err  output  1  as a one-cycle mismatch pulse coincident with done.
REQ-014 SHALL have port err_mask  output  WIDTH  holding the per-bit mismatch from the last check.
REQ-015 SHALL have port cur  output  WIDTH  as the tracked flop state.

Function
REQ-016 SHALL implement FSM states IDLE, DRIVE, SETTLE, CHECK.
REQ-017 SHALL drive in_ready = 1 only in IDLE; a transfer occurs on in_valid & in_ready at an edge.
REQ-018 SHALL on transfer register tgt = in_target, s_nxt = tgt & ~cur and r_nxt = ~tgt & cur.
REQ-019 SHALL on transfer go to DRIVE when tgt != cur, else go directly to CHECK.
REQ-020 SHALL assert s = s_nxt and r = r_nxt for exactly PULSE_CYC cycles in DRIVE, then go to SETTLE.
REQ-021 SHALL hold s = 0 and r = 0 in all states other than DRIVE.
REQ-022 SHALL never assert s[i] & r[i] for any i in any cycle, giving no 2'b11 excitation.
REQ-023 SHALL stay in SETTLE exactly SETTLE_CYC cycles, then go to CHECK.
REQ-024 SHALL spend exactly one cycle in CHECK, then go to IDLE.
REQ-025 SHALL on leaving CHECK pulse done high for one cycle, in the first IDLE cycle.
REQ-026 SHALL give latency, transfer edge to done high, of PULSE_CYC+SETTLE_CYC+2 cycles when tgt != cur, and 2 cycles when tgt == cur.
REQ-027 SHALL on leaving CHECK update cur as defined under Configuration.
REQ-028 SHALL ignore in_valid in all states except IDLE; a new transfer may occur in the same cycle done is high.
REQ-029 SHALL implement internal cycle counters 4 bits wide, reloaded on each state entry.

Reset
REQ-030 SHALL, when rst is high at an edge, force state IDLE, s=0, r=0, done=0, err=0, err_mask=0, cur=0, in_ready=1 from the next cycle.
REQ-031 SHALL, when rst occurs mid DRIVE/SETTLE/CHECK, abort the operation with no done or err pulse.
REQ-032 SHALL give rst priority over a simultaneous transfer; the transfer is dropped.

Configuration
REQ-033 SHALL, with macro SR_DRV_VERIFY_EN defined, compute err_mask = q_fb ^ tgt in CHECK, pulse err = |err_mask with done, and set cur <= q_fb.
REQ-034 SHALL, without SR_DRV_VERIFY_EN, leave q_fb unused, tie err = 0 and err_mask = 0, and set cur <= tgt.

Verification
REQ-035 SHALL cover: rst, then WIDTH=4, PULSE=2, SETTLE=1, target 4'b1010, q_fb follows s/r -> s=1010, r=0000 for 2 cycles, done 5 cycles after transfer, cur=1010, err=0.
REQ-036 SHALL cover: from cur=1010, target 0110 -> s=0100, r=1000 for 2 cycles; s&r==0 every cycle; cur=0110.
REQ-037 SHALL cover: target equal to cur (0110) -> no s/r activity, done 2 cycles after transfer.
REQ-038 SHALL cover, with VERIFY_EN: target 1111 and q_fb stuck at 0111 -> err=1 with done, err_mask=1000, cur=0111.
REQ-039 SHALL cover: rst asserted during DRIVE -> s=r=0 next cycle, no done, cur=0, in_ready=1.
REQ-040 SHALL cover: in_valid held high during busy -> no second transfer until IDLE; back-to-back transfer in the done cycle is accepted.
